// File: rtl/req_encoder_pkg.sv
// rtl/req_encoder_pkg.sv - shared types and constants for the request encoder
package req_encoder_pkg;

    localparam int NUM_REQ = 4;
    localparam int CODE_W  = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/req_encoder_pick.sv
// rtl/req_encoder_pick.sv - selects the next pending request to grant
// Macro REQ_ENCODER_RR_EN selects round-robin search from pointer+1; otherwise fixed priority, highest index wins.
module req_encoder_pick
    import req_encoder_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending,
    input  logic [CODE_W-1:0]  pointer,
    output logic [CODE_W-1:0]  index,
    output logic               any
);

`ifdef REQ_ENCODER_RR_EN
    logic [CODE_W-1:0] w_cand;

    // Walk the search order backwards so the earliest candidate after the pointer wins.
    always_comb begin
        index  = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = pointer + CODE_W'(k);
            if (pending[w_cand]) begin
                index = w_cand;
                any   = 1'b1;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^pointer;

    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pending[k]) begin
                index = CODE_W'(k);
                any   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - captures request lines, presents one 2-bit code at a time with ack handshake
// Macro REQ_ENCODER_RR_EN enables round-robin arbitration with a pointer register.
module req_encoder
    import req_encoder_pkg::*;
#(
    parameter int EDGE_MODE = 1
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic E,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic ack,
    output logic x0,
    output logic x1,
    output logic valid,
    output logic overflow
);

    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_prev;
    logic [NUM_REQ-1:0] w_sample;
    logic [NUM_REQ-1:0] w_event;
    logic [NUM_REQ-1:0] w_clr;
    logic               w_lost;
    state_t             r_state;
    logic [CODE_W-1:0]  r_code;
    logic               r_valid;
    logic               r_overflow;
    logic [CODE_W-1:0]  w_index;
    logic [CODE_W-1:0]  w_ptr;
    logic               w_any;

    assign w_sample = {y3, y2, y1, y0};

    always_comb begin
        w_event = '0;
        if (!E) begin
            w_event = (EDGE_MODE != 0) ? (w_sample & ~r_prev) : w_sample;
        end
        w_clr = '0;
        if (r_state == PRESENT && ack) begin
            w_clr[r_code] = 1'b1;
        end
    end

    // A set racing the clear of the same bit is not a loss; only already-held bits overflow.
    assign w_lost = |(w_event & r_pending & ~w_clr);

`ifdef REQ_ENCODER_RR_EN
    logic [CODE_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state == PRESENT && ack) begin
            r_ptr <= r_code;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    req_encoder_pick u_pick (
        .pending (r_pending),
        .pointer (w_ptr),
        .index   (w_index),
        .any     (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_prev     <= '0;
            r_state    <= IDLE;
            r_code     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_prev     <= w_sample;
            r_pending  <= (r_pending & ~w_clr) | w_event;
            r_overflow <= w_lost;
            case (r_state)
                IDLE: begin
                    if (!E && w_any) begin
                        r_code  <= w_index;
                        r_valid <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x0       = r_code[1];
    assign x1       = r_code[0];
    assign valid    = r_valid;
    assign overflow = r_overflow;

endmodule
